// File: rtl/key_pkg.sv
// Shared definitions for the key bounce generator: FSM encoding, LFSR constants
// and a saturating counter helper.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE_HI  = 2'd0,
    P_BOUNCE = 2'd1,
    HELD_LO  = 2'd2,
    R_BOUNCE = 2'd3
  } key_fsm_e;

  // Fibonacci taps 16,14,13,11 expressed as 0-based bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAP_MASK     = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/key_lfsr16.sv
// 16-bit Fibonacci LFSR that shifts left by one position each cycle adv is high.
module key_lfsr16
  import key_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adv,
  output logic [15:0] q
);

  logic [15:0] q_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= SEED;
    end else if (adv) begin
      q_q <= {q_q[14:0], ^(q_q & LFSR_TAP_MASK)};
    end
  end

  assign q = q_q;

endmodule

// File: rtl/key_bounce_gen.sv
// Mechanical key emulator: press/release commands produce a bouncing key line that
// settles after BOUNCE_TIME cycles. Define KEY_BOUNCE_LFSR_EN for pseudo-random bounce.
module key_bounce_gen
  import key_pkg::*;
#(
  parameter logic [19:0] BOUNCE_TIME = 20'd200_000,
  parameter logic [15:0] BOUNCE_STEP = 16'd5_000,
  parameter logic [15:0] LFSR_SEED   = LFSR_SEED_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic       cmd_press,
  output logic       cmd_ready,
  output logic       key_out,
  output logic       key_state,
  output logic       done,
  output logic [7:0] bounce_cnt
);

  localparam logic [19:0] CNT_LAST  = BOUNCE_TIME - 20'd1;
  localparam logic [15:0] STEP_LAST = BOUNCE_STEP - 16'd1;

  if (BOUNCE_TIME < 20'd2) begin : g_bad_time
    $error("key_bounce_gen: BOUNCE_TIME must be >= 2");
  end
  if (BOUNCE_STEP < 16'd1) begin : g_bad_step
    $error("key_bounce_gen: BOUNCE_STEP must be >= 1");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("key_bounce_gen: LFSR_SEED must be nonzero");
  end

  key_fsm_e    state_q;
  logic [19:0] cnt_q;
  logic [15:0] step_q;
  logic        ready_q, key_out_q, key_state_q, done_q;
  logic [7:0]  bcnt_q;

  logic in_bounce, settle, opp, toggle_d;

  // step_q tracks cnt % BOUNCE_STEP without a divider; both restart at zero on accept
  assign in_bounce = (state_q == P_BOUNCE) || (state_q == R_BOUNCE);
  assign settle    = in_bounce && (cnt_q == CNT_LAST);
  assign opp       = in_bounce && (step_q == STEP_LAST) && !settle;

`ifdef KEY_BOUNCE_LFSR_EN
  logic [15:0] lfsr_q;

  key_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (opp),
    .q     (lfsr_q)
  );

  assign toggle_d = opp && lfsr_q[0];
`else
  assign toggle_d = opp;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE_HI;
      cnt_q       <= '0;
      step_q      <= '0;
      ready_q     <= 1'b1;
      key_out_q   <= 1'b1;
      key_state_q <= 1'b1;
      done_q      <= 1'b0;
      bcnt_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE_HI, HELD_LO: begin
          if (cmd_valid) begin
            // Redundant commands complete immediately and leave the line untouched
            if (cmd_press == (state_q == IDLE_HI)) begin
              state_q   <= cmd_press ? P_BOUNCE : R_BOUNCE;
              key_out_q <= !cmd_press;
              cnt_q     <= '0;
              step_q    <= '0;
              bcnt_q    <= '0;
              ready_q   <= 1'b0;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        P_BOUNCE, R_BOUNCE: begin
          if (settle) begin
            key_out_q   <= (state_q == R_BOUNCE);
            key_state_q <= (state_q == R_BOUNCE);
            state_q     <= (state_q == R_BOUNCE) ? IDLE_HI : HELD_LO;
            done_q      <= 1'b1;
            ready_q     <= 1'b1;
          end else begin
            cnt_q  <= cnt_q + 20'd1;
            step_q <= (step_q == STEP_LAST) ? 16'd0 : step_q + 16'd1;
            if (toggle_d) begin
              key_out_q <= !key_out_q;
              bcnt_q    <= sat_inc8(bcnt_q);
            end
          end
        end
        default: begin
          state_q <= IDLE_HI;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready  = ready_q;
  assign key_out    = key_out_q;
  assign key_state  = key_state_q;
  assign done       = done_q;
  assign bounce_cnt = bcnt_q;

endmodule

// File: tb/tb_key_bounce_gen.sv
// Self-checking bench for key_bounce_gen: table of commands plus reset, back-pressure,
// no-bounce and saturation sequences; completions checked through a scoreboard queue.
module tb_key_bounce_gen;

  localparam int BT = 100;
  localparam int BS = 10;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic cmd_valid = 1'b0, cmd_press = 1'b0;
  logic cmd_ready, key_out, key_state, done;
  logic [7:0] bounce_cnt;

  logic v2 = 1'b0, p2 = 1'b0;
  logic r2, ko2, ks2, d2, r3, ko3, ks3, d3;
  logic [7:0] bc2, bc3;

  key_bounce_gen #(.BOUNCE_TIME(20'd100), .BOUNCE_STEP(16'd10), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_press(cmd_press),
    .cmd_ready(cmd_ready), .key_out(key_out), .key_state(key_state), .done(done),
    .bounce_cnt(bounce_cnt));

  key_bounce_gen #(.BOUNCE_TIME(20'd300), .BOUNCE_STEP(16'd1), .LFSR_SEED(SEED)) dut_sat (
    .clk(clk), .rst_n(rst_n), .cmd_valid(v2), .cmd_press(p2),
    .cmd_ready(r2), .key_out(ko2), .key_state(ks2), .done(d2), .bounce_cnt(bc2));

  key_bounce_gen #(.BOUNCE_TIME(20'd8), .BOUNCE_STEP(16'd8), .LFSR_SEED(SEED)) dut_clean (
    .clk(clk), .rst_n(rst_n), .cmd_valid(v2), .cmd_press(p2),
    .cmd_ready(r3), .key_out(ko3), .key_state(ks3), .done(d3), .bounce_cnt(bc3));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         acc;
    int         lat;
    logic       ks;
    logic [7:0] bc;
    logic       ko;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic       press;
    logic       exp_ks;
    logic [7:0] exp_bc;
  } vec_t;
  vec_t tbl[6];

  logic [15:0] m_lf = SEED;
  logic        m_key = 1'b1, m_st = 1'b1;
  logic [7:0]  m_bc = 8'd0;
  logic        exp_wave[0:300];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour for one accepted command; lat counts edges from accept to done
  task automatic model_cmd(input logic press, input int t, input int s,
                           inout logic [15:0] lf, inout logic key, inout logic st,
                           inout logic [7:0] bc, output int lat);
    logic tgt;
    tgt = !press;
    if (tgt == st) begin
      lat = 0;
      return;
    end
    key = tgt;
    bc = 8'd0;
    exp_wave[0] = key;
    for (int k = 1; k < t; k++) begin
      if (k % s == 0) begin
`ifdef KEY_BOUNCE_LFSR_EN
        if (lf[0]) begin
          key = ~key;
          if (bc != 8'hFF) bc = bc + 8'd1;
        end
        lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
`else
        key = ~key;
        if (bc != 8'hFF) bc = bc + 8'd1;
`endif
      end
      exp_wave[k] = key;
    end
    key = tgt;
    st = tgt;
    exp_wave[t] = key;
    lat = t;
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("latency", cyc - e.acc, e.lat);
        chk("done_key_state", {31'd0, key_state}, {31'd0, e.ks});
        chk("done_bounce_cnt", {24'd0, bounce_cnt}, {24'd0, e.bc});
        chk("done_key_out", {31'd0, key_out}, {31'd0, e.ko});
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 4 * BT) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 4 * BT) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  task automatic push_model(input logic press, input int acc);
    exp_t e;
    int lat;
    model_cmd(press, BT, BS, m_lf, m_key, m_st, m_bc, lat);
    e.acc = acc; e.lat = lat; e.ks = m_st; e.bc = m_bc; e.ko = m_key;
    sb.push_back(e);
  endtask

  // Drives one command at a negedge and checks the key waveform while it bounces
  task automatic issue(input logic press);
    logic bouncing;
    wait_ready();
    bouncing = (!press) != m_st;
    push_model(press, cyc + 1);
    cmd_valid = 1'b1;
    cmd_press = press;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (bouncing) begin
      for (int k = 0; k < BT; k++) begin
        chk("wave_key_out", {31'd0, key_out}, {31'd0, exp_wave[k]});
        chk("busy_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
      end
    end
    wait_drain();
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 8'd9};
    tbl[1] = '{1'b0, 1'b1, 8'd9};
    tbl[2] = '{1'b0, 1'b1, 8'd9};
    tbl[3] = '{1'b1, 1'b0, 8'd9};
    tbl[4] = '{1'b1, 1'b0, 8'd9};
    tbl[5] = '{1'b0, 1'b1, 8'd9};

    repeat (3) @(negedge clk);
    chk("rst_key_out", {31'd0, key_out}, 32'd1);
    chk("rst_key_state", {31'd0, key_state}, 32'd1);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_bounce_cnt", {24'd0, bounce_cnt}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      issue(tbl[i].press);
      chk("tbl_key_state", {31'd0, key_state}, {31'd0, tbl[i].exp_ks});
      chk("tbl_key_out", {31'd0, key_out}, {31'd0, tbl[i].exp_ks});
`ifndef KEY_BOUNCE_LFSR_EN
      chk("tbl_bounce_cnt", {24'd0, bounce_cnt}, {24'd0, tbl[i].exp_bc});
`endif
    end

    // Command held through the press bounce; a release waits behind it
    wait_ready();
    begin
      int acc1;
      acc1 = cyc + 1;
      push_model(1'b1, acc1);
      cmd_valid = 1'b1;
      cmd_press = 1'b1;
      @(negedge clk);
      cmd_press = 1'b0;
      push_model(1'b0, acc1 + BT + 1);
      for (int k = 0; k < BT; k++) begin
        chk("held_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
      end
      chk("settle_ready", {31'd0, cmd_ready}, 32'd1);
      chk("settle_key_out", {31'd0, key_out}, 32'd0);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("second_accept_ready", {31'd0, cmd_ready}, 32'd0);
      chk("second_accept_key", {31'd0, key_out}, 32'd1);
      wait_drain();
    end

    // Reset in the middle of a press bounce
    wait_ready();
    cmd_valid = 1'b1;
    cmd_press = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (47) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midrst_key_out", {31'd0, key_out}, 32'd1);
    chk("midrst_key_state", {31'd0, key_state}, 32'd1);
    chk("midrst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_bounce_cnt", {24'd0, bounce_cnt}, 32'd0);
    m_lf = SEED; m_key = 1'b1; m_st = 1'b1; m_bc = 8'd0;
    rst_n = 1'b1;
    push_model(1'b1, cyc + 1);
    cmd_valid = 1'b1;
    cmd_press = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("first_accept_key", {31'd0, key_out}, 32'd0);
    chk("first_accept_ready", {31'd0, cmd_ready}, 32'd0);
    wait_drain();

    // No-bounce and saturation instances share one command stream
    begin
      int acc2, n, lat_dummy;
      logic bounced;
      logic [15:0] lf2;
      logic key2, st2;
      logic [7:0] exp_bc2;
      lf2 = SEED; key2 = 1'b1; st2 = 1'b1; exp_bc2 = 8'd0;
      model_cmd(1'b1, 300, 1, lf2, key2, st2, exp_bc2, lat_dummy);
      acc2 = cyc + 1;
      v2 = 1'b1;
      p2 = 1'b1;
      @(negedge clk);
      v2 = 1'b0;
      chk("clean_ready", {31'd0, r3}, 32'd0);
      chk("sat_ready", {31'd0, r2}, 32'd0);
      bounced = 1'b0;
      n = 0;
      while (!d3 && n < 50) begin
        if (ko3 !== 1'b0) bounced = 1'b1;
        @(negedge clk);
        n++;
      end
      chk("clean_latency", cyc - acc2, 32'd8);
      chk("clean_no_toggle", {31'd0, bounced}, 32'd0);
      chk("clean_bounce_cnt", {24'd0, bc3}, 32'd0);
      chk("clean_key_state", {31'd0, ks3}, 32'd0);
      n = 0;
      while (!d2 && n < 400) begin
        @(negedge clk);
        n++;
      end
      chk("sat_latency", cyc - acc2, 32'd300);
      chk("sat_bounce_cnt", {24'd0, bc2}, {24'd0, exp_bc2});
      chk("sat_key_out", {31'd0, ko2}, 32'd0);
      chk("sat_key_state", {31'd0, ks2}, 32'd0);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_bounce_gen.md
KEY_BOUNCE_GEN -- requirements
Module: key_bounce_gen

Interface
REQ-001 SHALL have parameter BOUNCE_TIME, default 20'd200_000: length of each bounce window, in clk cycles (legal range >= 2).
REQ-002 SHALL have parameter BOUNCE_STEP, default 16'd5_000: spacing of bounce toggle opportunities, in cycles (legal range >= 1).
REQ-003 SHALL have parameter LFSR_SEED, default 16'hACE1: LFSR reset value (must be nonzero).
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_press  input  1  command type: 1 = press (drive key low), 0 = release (drive key high).
REQ-008 cmd_ready  output  1  command accepted on a cycle where cmd_valid && cmd_ready.
REQ-009 key_out  output  1  emulated mechanical key line; idle high, pressed low.
REQ-010 key_state  output  1  settled level: 1 released, 0 pressed; unchanged during bounce.
REQ-011 done  output  1  one-cycle pulse when a command completes.
REQ-012 bounce_cnt  output  8  toggles issued in the current or most recent bounce window; saturates at 255.

Function
REQ-013 SHALL implement FSM states IDLE_HI, P_BOUNCE, HELD_LO and R_BOUNCE; all outputs SHALL be registered.
REQ-014 cmd_ready SHALL be 1 only in IDLE_HI and HELD_LO; commands during P_BOUNCE/R_BOUNCE are not accepted and must be held by the source.
REQ-015 Press accepted in IDLE_HI at edge N: at N+1, state SHALL be P_BOUNCE, key_out 0, cnt 0 and bounce_cnt 0.
REQ-016 Release accepted in HELD_LO: mirror of REQ-015, with state R_BOUNCE and key_out 1.
REQ-017 In a bounce state, cnt SHALL increment each cycle; when cnt%BOUNCE_STEP == BOUNCE_STEP-1 and cnt != BOUNCE_TIME-1, key_out SHALL toggle, subject to REQ-026.
REQ-018 Each toggle SHALL increment bounce_cnt, saturating at 255.
REQ-019 At the edge where cnt == BOUNCE_TIME-1: key_out forced to the target level, key_state updated, done=1 for one cycle, state goes to HELD_LO or IDLE_HI.
REQ-020 Latency SHALL be exactly BOUNCE_TIME cycles from the accept edge to the settle edge.
REQ-021 A redundant command (press in HELD_LO, release in IDLE_HI) SHALL be accepted; done=1 on the next cycle; key_out, key_state and bounce_cnt unchanged.
REQ-022 If BOUNCE_STEP >= BOUNCE_TIME, no toggles occur: a clean single edge and bounce_cnt = 0.
REQ-023 cnt width SHALL be 20 bits; no wrap can occur within a legal BOUNCE_TIME.

Reset
REQ-024 With rst_n=0 sampled on a clk edge, including mid-bounce: state IDLE_HI, key_out 1, key_state 1, cmd_ready 1, done 0, bounce_cnt 0, cnt 0, LFSR = LFSR_SEED.
REQ-025 First accept is possible on the first edge after rst_n returns high.

Configuration
REQ-026 Macro KEY_BOUNCE_LFSR_EN defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance once per toggle opportunity; the toggle occurs only if LFSR bit 0 == 1.
REQ-027 Macro KEY_BOUNCE_LFSR_EN undefined: every toggle opportunity SHALL toggle (deterministic), and no LFSR logic shall be present.

Structure
REQ-028 Package key_pkg SHALL hold the FSM state encoding, the LFSR tap mask and the default seed.
REQ-029 The LFSR SHALL be a sub-module key_lfsr16 with ports clk, rst_n, adv and q[15:0], instantiated only under KEY_BOUNCE_LFSR_EN.

Verification (macro off, BOUNCE_TIME=100, BOUNCE_STEP=10 unless stated)
REQ-030 Press at edge 0 -> key_out 0 at edge 1; toggles at edges 10,20,...,90; forced 0 at edge 100; done pulse; bounce_cnt=9; key_state 0.
REQ-031 Release from HELD_LO -> mirror waveform; key_out and key_state end at 1; bounce_cnt=9; done once.
REQ-032 cmd_valid held high during P_BOUNCE -> cmd_ready 0 throughout; second command accepted on the cycle after settle.
REQ-033 rst_n low at cnt=47 of P_BOUNCE -> next edge: key_out 1, IDLE_HI, bounce_cnt 0, no done.
REQ-034 Press in HELD_LO -> done next cycle; key_out stays 0; no toggles.
REQ-035 Macro on, seed 16'hACE1 -> toggle pattern matches the golden LFSR model; bounce_cnt equals the number of toggles; final level correct.
